// File: rtl/ec_fp_resource_arb.sv
// Shares one pipelined field-arithmetic unit among NUM_IN requesters: round-robin
// request arbitration with requester tagging, tag-routed results and credit tracking.
module ec_fp_resource_arb #(
    parameter int NUM_IN      = 4,
    parameter int REQ_BITS    = 762,
    parameter int RES_BITS    = 381,
    parameter int CTL_BITS    = 16,
    parameter int OVR_WRT_BIT = 12,
    parameter int MAX_OUT     = 15
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_IN*REQ_BITS-1:0] i_req_dat,
    input  logic [NUM_IN*CTL_BITS-1:0] i_req_ctl,
    input  logic [NUM_IN-1:0]          i_req_val,
    output logic [NUM_IN-1:0]          o_req_rdy,
    output logic [REQ_BITS-1:0]        o_unit_dat,
    output logic [CTL_BITS-1:0]        o_unit_ctl,
    output logic                       o_unit_val,
    input  logic                       i_unit_rdy,
    input  logic [RES_BITS-1:0]        i_unit_dat,
    input  logic [CTL_BITS-1:0]        i_unit_ctl,
    input  logic                       i_unit_val,
    output logic                       o_unit_rdy,
    output logic [RES_BITS-1:0]        o_res_dat,
    output logic [CTL_BITS-1:0]        o_res_ctl,
    output logic [NUM_IN-1:0]          o_res_val,
    input  logic [NUM_IN-1:0]          i_res_rdy,
    output logic                       o_err
);
    localparam int ID_BITS  = $clog2(NUM_IN);
    localparam int SUM_BITS = ID_BITS + 1;
    localparam int CNT_BITS = $clog2(MAX_OUT + 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(MAX_OUT);
    localparam logic [ID_BITS-1:0]  ID_LAST = ID_BITS'(NUM_IN - 1);

    logic [ID_BITS-1:0]  ptr_r;
    logic [CNT_BITS-1:0] cnt_r [NUM_IN];
    logic                err_r;

    logic                free_s;
    logic                grant_val_s;
    logic                accept_s;
    logic [ID_BITS-1:0]  grant_id_s;
    logic [SUM_BITS-1:0] sum_s;
    logic [ID_BITS-1:0]  idx_s;
    logic                hit_s;
    logic [CTL_BITS-1:0] tagged_ctl_s;
    logic [ID_BITS-1:0]  res_id_s;
    logic                res_id_ok_s;
    logic                res_hs_s;
    logic [NUM_IN-1:0]   inc_s;
    logic [NUM_IN-1:0]   dec_s;
    logic                underflow_s;

    assign free_s   = ~o_unit_val | i_unit_rdy;
    assign accept_s = free_s & grant_val_s & i_rst_n;

    // Round-robin search from the pointer; iterating downward lets the smallest offset win.
    always_comb begin
        grant_val_s = 1'b0;
        grant_id_s  = '0;
        sum_s       = '0;
        idx_s       = '0;
        hit_s       = 1'b0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            sum_s       = {1'b0, ptr_r} + SUM_BITS'(i);
            idx_s       = (sum_s >= SUM_BITS'(NUM_IN)) ? ID_BITS'(sum_s - SUM_BITS'(NUM_IN))
                                                       : ID_BITS'(sum_s);
            hit_s       = i_req_val[idx_s] & (cnt_r[idx_s] < CNT_MAX);
            grant_val_s = grant_val_s | hit_s;
            grant_id_s  = hit_s ? idx_s : grant_id_s;
        end
    end

    // Requester ctl with the tag field replaced by the granted channel index.
    always_comb begin
        tagged_ctl_s = i_req_ctl[grant_id_s*CTL_BITS +: CTL_BITS];
        tagged_ctl_s[OVR_WRT_BIT +: ID_BITS] = grant_id_s;
    end

    // One-hot ready to the granted requester only.
    always_comb begin
        o_req_rdy = '0;
        if (accept_s) begin
            o_req_rdy[grant_id_s] = 1'b1;
        end else begin
            o_req_rdy = '0;
        end
    end

    assign res_id_s    = i_unit_ctl[OVR_WRT_BIT +: ID_BITS];
    assign res_id_ok_s = ({1'b0, res_id_s} < SUM_BITS'(NUM_IN));
    assign o_res_dat   = i_unit_dat;
    assign o_res_ctl   = i_unit_ctl;

    // Result routing by tag; an out-of-range tag is drained so the unit cannot lock up.
    always_comb begin
        o_res_val  = '0;
        o_unit_rdy = 1'b0;
        if (!i_rst_n) begin
            o_unit_rdy = 1'b0;
        end else if (!res_id_ok_s) begin
            o_unit_rdy = 1'b1;
        end else begin
            o_res_val[res_id_s] = i_unit_val;
            o_unit_rdy          = i_res_rdy[res_id_s];
        end
    end

    assign res_hs_s = i_unit_val & o_unit_rdy;

    // Per-channel credit events and zero-count response detection.
    always_comb begin
        inc_s       = '0;
        dec_s       = '0;
        underflow_s = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            inc_s[k]    = accept_s & (grant_id_s == ID_BITS'(k));
            dec_s[k]    = res_hs_s & res_id_ok_s & (res_id_s == ID_BITS'(k));
            underflow_s = underflow_s | (dec_s[k] & (cnt_r[k] == '0));
        end
    end

    // Registered request stage toward the shared unit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_unit_val <= 1'b0;
            o_unit_dat <= '0;
            o_unit_ctl <= '0;
            ptr_r      <= '0;
        end else if (free_s) begin
            if (grant_val_s) begin
                o_unit_val <= 1'b1;
                o_unit_dat <= i_req_dat[grant_id_s*REQ_BITS +: REQ_BITS];
                o_unit_ctl <= tagged_ctl_s;
                ptr_r      <= (grant_id_s == ID_LAST) ? '0 : grant_id_s + ID_BITS'(1);
            end else begin
                o_unit_val <= 1'b0;
            end
        end
    end

    // Outstanding counters and sticky protocol error.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NUM_IN; k++) begin
                cnt_r[k] <= '0;
            end
            err_r <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                case ({inc_s[k], dec_s[k]})
                    2'b10:   cnt_r[k] <= cnt_r[k] + CNT_BITS'(1);
                    2'b01:   cnt_r[k] <= (cnt_r[k] == '0) ? '0 : cnt_r[k] - CNT_BITS'(1);
                    default: cnt_r[k] <= cnt_r[k];
                endcase
            end
            err_r <= err_r | underflow_s | (res_hs_s & ~res_id_ok_s);
        end
    end

    assign o_err = err_r;

endmodule

// File: tb/tb_ec_fp_resource_arb.sv
// Randomized traffic checked against a transaction-level model of the arbiter,
// with directed single-request, contention, credit-limit, error and reset cases.
module tb_ec_fp_resource_arb;
    localparam int NUM_IN      = 4;
    localparam int REQ_BITS    = 762;
    localparam int RES_BITS    = 381;
    localparam int CTL_BITS    = 16;
    localparam int OVR_WRT_BIT = 12;
    localparam int MAX_OUT     = 15;
    localparam int ID_BITS     = $clog2(NUM_IN);
    localparam int HALF        = REQ_BITS / 2;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [NUM_IN*REQ_BITS-1:0] i_req_dat;
    logic [NUM_IN*CTL_BITS-1:0] i_req_ctl;
    logic [NUM_IN-1:0]          i_req_val;
    logic [NUM_IN-1:0]          o_req_rdy;
    logic [REQ_BITS-1:0]        o_unit_dat;
    logic [CTL_BITS-1:0]        o_unit_ctl;
    logic                       o_unit_val;
    logic                       i_unit_rdy;
    logic [RES_BITS-1:0]        i_unit_dat;
    logic [CTL_BITS-1:0]        i_unit_ctl;
    logic                       i_unit_val;
    logic                       o_unit_rdy;
    logic [RES_BITS-1:0]        o_res_dat;
    logic [CTL_BITS-1:0]        o_res_ctl;
    logic [NUM_IN-1:0]          o_res_val;
    logic [NUM_IN-1:0]          i_res_rdy;
    logic                       o_err;

    always #5 clk = ~clk;

    ec_fp_resource_arb #(
        .NUM_IN(NUM_IN), .REQ_BITS(REQ_BITS), .RES_BITS(RES_BITS),
        .CTL_BITS(CTL_BITS), .OVR_WRT_BIT(OVR_WRT_BIT), .MAX_OUT(MAX_OUT)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_dat(i_req_dat), .i_req_ctl(i_req_ctl), .i_req_val(i_req_val), .o_req_rdy(o_req_rdy),
        .o_unit_dat(o_unit_dat), .o_unit_ctl(o_unit_ctl), .o_unit_val(o_unit_val), .i_unit_rdy(i_unit_rdy),
        .i_unit_dat(i_unit_dat), .i_unit_ctl(i_unit_ctl), .i_unit_val(i_unit_val), .o_unit_rdy(o_unit_rdy),
        .o_res_dat(o_res_dat), .o_res_ctl(o_res_ctl), .o_res_val(o_res_val), .i_res_rdy(i_res_rdy),
        .o_err(o_err)
    );

    typedef struct {
        logic [RES_BITS-1:0] dat;
        logic [CTL_BITS-1:0] ctl;
    } res_t;

    res_t                pipe_q[$];
    res_t                rsp_cur;
    bit                  rsp_busy;
    int                  rsp_pct;
    int                  m_ptr;
    int                  m_cnt [NUM_IN];
    bit                  m_err;
    bit                  m_uval;
    logic [REQ_BITS-1:0] m_udat;
    logic [CTL_BITS-1:0] m_uctl;
    int                  total = 0;
    int                  bad   = 0;

    task automatic check_val(input string tag, input logic [REQ_BITS-1:0] got,
                             input logic [REQ_BITS-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [REQ_BITS-1:0] make_ops(input logic [31:0] a, input logic [31:0] b);
        logic [REQ_BITS-1:0] v;
        v = '0;
        v[31:0] = a;
        v[HALF +: 32] = b;
        return v;
    endfunction

    task automatic model_reset();
        m_ptr  = 0;
        for (int k = 0; k < NUM_IN; k++) m_cnt[k] = 0;
        m_err  = 1'b0;
        m_uval = 1'b0;
        m_udat = '0;
        m_uctl = '0;
        pipe_q.delete();
        rsp_busy = 1'b0;
    endtask

    task automatic drive_random(input logic [NUM_IN-1:0] en, input int req_pct,
                                input int urdy_pct, input int rrdy_pct);
        for (int k = 0; k < NUM_IN; k++) begin
            i_req_val[k] = en[k] && ($urandom_range(99) < req_pct);
            i_req_dat[k*REQ_BITS +: REQ_BITS] = make_ops($urandom, $urandom);
            i_req_ctl[k*CTL_BITS +: CTL_BITS] = CTL_BITS'($urandom);
            i_res_rdy[k] = ($urandom_range(99) < rrdy_pct);
        end
        i_unit_rdy = ($urandom_range(99) < urdy_pct);
    endtask

    // One clock: present a unit result, check combinational outputs, advance model, check registers.
    task automatic step();
        int                  g;
        int                  id;
        bit                  free;
        bit                  exp_urdy;
        bit                  dec;
        logic [NUM_IN-1:0]   exp_rdy;
        logic [NUM_IN-1:0]   exp_rval;
        logic [63:0]         prod;
        res_t                r;
        if (!rsp_busy && pipe_q.size() > 0 && $urandom_range(99) < rsp_pct) begin
            rsp_cur  = pipe_q.pop_front();
            rsp_busy = 1'b1;
        end
        i_unit_val = rsp_busy;
        i_unit_dat = rsp_busy ? rsp_cur.dat : '0;
        i_unit_ctl = rsp_busy ? rsp_cur.ctl : '0;
        #1;
        free = !m_uval || i_unit_rdy;
        g = -1;
        if (free) begin
            for (int j = 0; j < NUM_IN; j++) begin
                int c;
                c = (m_ptr + j) % NUM_IN;
                if (g < 0 && i_req_val[c] && m_cnt[c] < MAX_OUT) g = c;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        id = int'(i_unit_ctl[OVR_WRT_BIT +: ID_BITS]);
        exp_urdy = i_res_rdy[id];
        exp_rval = '0;
        if (rsp_busy) exp_rval[id] = 1'b1;
        check_val("req_rdy", o_req_rdy, exp_rdy);
        check_val("unit_rdy", o_unit_rdy, exp_urdy);
        check_val("res_val", o_res_val, exp_rval);
        if (rsp_busy) begin
            check_val("res_dat", o_res_dat, rsp_cur.dat);
            check_val("res_ctl", o_res_ctl, rsp_cur.ctl);
        end
        if (m_uval && i_unit_rdy) begin
            prod  = {32'd0, m_udat[31:0]} * {32'd0, m_udat[HALF +: 32]};
            r.dat = RES_BITS'(prod);
            r.ctl = m_uctl;
            pipe_q.push_back(r);
        end
        dec = rsp_busy && exp_urdy;
        if (dec && m_cnt[id] == 0) m_err = 1'b1;
        if (g >= 0 && !(dec && g == id)) m_cnt[g]++;
        if (dec && g != id && m_cnt[id] > 0) m_cnt[id]--;
        if (dec) rsp_busy = 1'b0;
        if (free) begin
            if (g >= 0) begin
                m_uval = 1'b1;
                m_udat = i_req_dat[g*REQ_BITS +: REQ_BITS];
                m_uctl = i_req_ctl[g*CTL_BITS +: CTL_BITS];
                m_uctl[OVR_WRT_BIT +: ID_BITS] = ID_BITS'(g);
                m_ptr  = (g + 1) % NUM_IN;
            end else begin
                m_uval = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check_val("unit_val", o_unit_val, m_uval);
        if (m_uval) begin
            check_val("unit_dat", o_unit_dat, m_udat);
            check_val("unit_ctl", o_unit_ctl, m_uctl);
        end
        check_val("err", o_err, m_err);
    endtask

    initial begin
        res_t rogue;
        rst_n      = 1'b1;
        i_req_val  = '1;
        i_req_dat  = '0;
        i_req_ctl  = '0;
        i_unit_rdy = 1'b1;
        i_unit_val = 1'b1;
        i_unit_dat = '0;
        i_unit_ctl = '0;
        i_res_rdy  = '1;
        rsp_pct    = 100;
        model_reset();
        #1 rst_n = 1'b0;
        #11;
        check_val("rst_unit_val", o_unit_val, 1'b0);
        check_val("rst_unit_dat", o_unit_dat, '0);
        check_val("rst_unit_ctl", o_unit_ctl, '0);
        check_val("rst_err", o_err, 1'b0);
        check_val("rst_req_rdy", o_req_rdy, '0);
        check_val("rst_res_val", o_res_val, '0);
        check_val("rst_unit_rdy", o_unit_rdy, 1'b0);
        i_req_val  = '0;
        i_unit_val = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single request from channel 2: 3 * 5 tagged 0x2001.
        i_req_val = 4'b0100;
        i_req_dat[2*REQ_BITS +: REQ_BITS] = make_ops(32'd3, 32'd5);
        i_req_ctl[2*CTL_BITS +: CTL_BITS] = 16'h0001;
        step();
        check_val("single_ctl", o_unit_ctl, 16'h2001);
        i_req_val = '0;
        repeat (4) step();

        // Contention, then unit backpressure, then recovery.
        repeat (16) begin drive_random(4'b1111, 100, 100, 100); step(); end
        repeat (5)  begin drive_random(4'b1111, 100, 0, 100);   step(); end
        repeat (8)  begin drive_random(4'b1111, 100, 100, 100); step(); end
        repeat (200) begin drive_random(4'b1111, 60, 80, 40);   step(); end

        // Credit limit on channel 0 with no results returned.
        repeat (60) begin drive_random(4'b0000, 0, 100, 100); step(); end
        rsp_pct = 0;
        repeat (20) begin drive_random(4'b0001, 100, 100, 100); step(); end
        repeat (6)  begin drive_random(4'b1001, 100, 100, 100); step(); end
        rsp_pct = 100;
        repeat (40) begin drive_random(4'b0001, 100, 100, 100); step(); end
        repeat (80) begin drive_random(4'b0000, 0, 100, 100);   step(); end

        // Result for channel 3 with nothing outstanding.
        rogue.dat = RES_BITS'($urandom);
        rogue.ctl = 16'h3000;
        pipe_q.push_front(rogue);
        repeat (4) begin drive_random(4'b0000, 0, 100, 100); step(); end
        check_val("err_sticky", o_err, 1'b1);

        rsp_pct = 70;
        repeat (1500) begin drive_random(NUM_IN'($urandom), 70, 75, 60); step(); end

        // Asynchronous reset in the middle of traffic.
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_unit_val", o_unit_val, 1'b0);
        check_val("arst_err", o_err, 1'b0);
        check_val("arst_req_rdy", o_req_rdy, '0);
        check_val("arst_res_val", o_res_val, '0);
        model_reset();
        i_unit_val = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (300) begin drive_random(NUM_IN'($urandom), 70, 75, 60); step(); end
        rsp_pct = 100;
        repeat (80) begin drive_random(4'b0000, 0, 100, 100); step(); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ec_fp_resource_arb.md
Name: ec_fp_resource_arb

Overview:
- Responder-side sharer for the field-arithmetic request interfaces (`o_mul_if`, `o_add_if`, `o_sub_if`) that the EC point blocks drive.
- Accepts operand requests from NUM_IN requesters and round-robin arbitrates them onto one shared pipelined unit (`ec_fp_mult_mod`, `adder_pipe` or `subtractor_pipe`).
- Tags each request's ctl with the requester index and routes each result back to its owner by that tag.
- Tracks outstanding operations per requester and flags protocol violations.

Parameters:
- NUM_IN, 4, number of requester channels (2..8).
- REQ_BITS, 762, request data width (operand b in the upper half, operand a in the lower half).
- RES_BITS, 381, result data width.
- CTL_BITS, 16, ctl width on both sides.
- OVR_WRT_BIT, 12, LSB of the ctl field overwritten with the requester index. The field is ID_BITS = $clog2(NUM_IN) wide.
- MAX_OUT, 15, maximum outstanding ops per requester.

Ports:
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_req_dat`  in  NUM_IN*REQ_BITS  requester operands, channel k at [k*REQ_BITS +: REQ_BITS].
- `i_req_ctl`  in  NUM_IN*CTL_BITS  requester ctl.
- `i_req_val`  in  NUM_IN  request valid per channel.
- `o_req_rdy`  out  NUM_IN  request accepted per channel.
- `o_unit_dat`  out  REQ_BITS  operands to the shared unit.
- `o_unit_ctl`  out  CTL_BITS  tagged ctl to the unit.
- `o_unit_val`  out  1  unit request valid.
- `i_unit_rdy`  in  1  unit ready.
- `i_unit_dat`  in  RES_BITS  unit result.
- `i_unit_ctl`  in  CTL_BITS  unit result ctl, tag preserved by the unit.
- `i_unit_val`  in  1  unit result valid.
- `o_unit_rdy`  out  1  result accepted.
- `o_res_dat`  out  RES_BITS  result, broadcast to all channels.
- `o_res_ctl`  out  CTL_BITS  result ctl, tag field unchanged.
- `o_res_val`  out  NUM_IN  one-hot result valid.
- `i_res_rdy`  in  NUM_IN  requester result ready.
- `o_err`  out  1  sticky protocol error.

Behaviour:
- Clocking and reset:
  - Single clock domain, `i_clk`.
  - `i_rst_n` low asynchronously clears: `o_unit_val`=0, `o_unit_dat`=0, `o_unit_ctl`=0, RR pointer=0, all outstanding counters=0, `o_err`=0.
  - Combinational outputs during reset: `o_req_rdy`=0; `o_res_val`=0 and `o_unit_rdy`=0.
  - Reset mid-operation drops any held request and in-flight bookkeeping without error.
- Request path (registered stage, 1-cycle latency):
  - Stage is "free" when `o_unit_val`=0 or `i_unit_rdy`=1.
  - When free, choose the first channel k, searching from the RR pointer upward with wrap-around, that has `i_req_val[k]`=1 and `cnt[k]` < MAX_OUT.
  - `o_req_rdy[k]`=1 combinationally for that channel only; all other channels see 0.
  - On the next edge, load `o_unit_dat`=`i_req_dat[k]` and `o_unit_ctl`=`i_req_ctl[k]` with bits [OVR_WRT_BIT +: ID_BITS] replaced by k. Set `o_unit_val`=1 and RR pointer = k+1 mod NUM_IN.
  - If free and no channel is eligible, `o_unit_val` clears and the pointer holds.
  - If not free, hold all outputs stable and keep every `o_req_rdy`=0.
  - Back-to-back: full throughput, one request per cycle while `i_unit_rdy`=1.
- Response path (combinational, 0 latency):
  - id = `i_unit_ctl`[OVR_WRT_BIT +: ID_BITS].
  - `o_res_val[id]` = `i_unit_val`; all other bits 0. `o_res_dat`/`o_res_ctl` pass through.
  - `o_unit_rdy` = `i_res_rdy[id]`. A stalled owner stalls the unit output; there is no bypass.
- Outstanding counters, one per channel, 4-bit for MAX_OUT=15:
  - +1 on request accept for that channel.
  - −1 on response handshake for that channel.
  - Both in the same cycle: unchanged.
  - Channel at MAX_OUT is skipped by arbitration until it drops.
- Errors (`o_err` sticky until reset):
  - Response handshake for a channel with `cnt`=0: set `o_err`; counter saturates at 0.
  - id ≥ NUM_IN, for non-power-of-two NUM_IN: set `o_err` and force `o_unit_rdy`=1 to drain the result.

Test Plan:
- Single request: ch2 sends a=3, b=5, ctl=0x0001 into `ec_fp_mult_mod` → unit sees ctl=0x2001 one cycle after the handshake. The result 15 returns with `o_res_val`=4'b0100 and ctl=0x2001. `cnt[2]` goes 1→0; `o_err`=0.
- Contention: all 4 channels valid continuously with `i_unit_rdy`=1 → grant order 0,1,2,3,0,1,… with one accept per cycle and no channel starved.
- Backpressure: `i_unit_rdy`=0 for 5 cycles with a request held → `o_unit_dat`/`o_unit_ctl` stable, all `o_req_rdy`=0. Resumes on the first rdy cycle with no loss or duplication.
- Response stall: result for ch1 with `i_res_rdy[1]`=0 for 3 cycles → `o_unit_rdy`=0 for those cycles. `o_res_val`=4'b0010 stays held; delivered on the 4th cycle.
- Credit limit: ch0 issues 15 requests with no responses returned → 16th request not granted while ch3 is still granted. After one response, ch0 is granted again.
- Errors and reset: inject a unit result tagged ch3 with `cnt[3]`=0 → `o_err`=1 and stays 1. Assert `i_rst_n`=0 mid-stream → `o_unit_val`=0 and `o_err`=0 immediately, asynchronously.
